// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard
//  Purpose  : Decode-stage scoreboard for the 8x16b bypassing register file.
//             Keeps a saturating pending-write counter per register and
//             raises a combinational stall when an issuing instruction would
//             read a register with an outstanding write, or would push a
//             destination counter past its maximum.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             issueValid/Wr/Dst - issuing instruction and its destination
//             src{1,2}Use/Sel   - source operands read by the instruction
//             wbEn/wbSel        - register file writeback (bypassed same cycle)
//             cancelEn/Sel      - squashed in-flight writer retired
//             stall             - issue not accepted this cycle
//             busyVec           - per-register pending flag from the counters
//             err               - sticky counter-underflow flag
//  Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int NREG = 8,
    parameter int CNTW = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issueValid,
    input  logic                    issueWr,
    input  logic [$clog2(NREG)-1:0] issueDst,
    input  logic                    src1Use,
    input  logic [$clog2(NREG)-1:0] src1Sel,
    input  logic                    src2Use,
    input  logic [$clog2(NREG)-1:0] src2Sel,
    input  logic                    wbEn,
    input  logic [$clog2(NREG)-1:0] wbSel,
    input  logic                    cancelEn,
    input  logic [$clog2(NREG)-1:0] cancelSel,
    output logic                    stall,
    output logic [NREG-1:0]         busyVec,
    output logic                    err
);

    localparam int              C_SELW    = $clog2(NREG);
    localparam logic [CNTW-1:0] C_CNT_MAX = '1;

    logic [CNTW-1:0] r_cnt [NREG];
    logic            r_err;

    logic [CNTW-1:0] w_eff [NREG];
    logic [NREG-1:0] w_under;
    logic            w_hazard;
    logic            w_full;
    logic            w_accept;

    // Effective count after this cycle's writeback/cancel. Because the
    // register file bypasses writeData, a register being written back now
    // is already readable, so hazard/full checks use the effective count.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            logic [CNTW:0] dec;
            logic [CNTW:0] cur;
            dec = {{CNTW{1'b0}}, (wbEn     && (wbSel     == C_SELW'(r)))}
                + {{CNTW{1'b0}}, (cancelEn && (cancelSel == C_SELW'(r)))};
            cur = {1'b0, r_cnt[r]};
            w_under[r] = (dec > cur);
            // Saturate at zero on underflow rather than wrapping.
            w_eff[r]   = w_under[r] ? '0 : CNTW'(cur - dec);
        end
    end

    always_comb begin
        w_hazard = (src1Use && (w_eff[src1Sel] != '0))
                 || (src2Use && (w_eff[src2Sel] != '0));
        w_full   = issueWr && (w_eff[issueDst] == C_CNT_MAX);
        // Gated by rst so no stall is shown while the pipeline is flushed.
        stall    = issueValid && !rst && (w_hazard || w_full);
        w_accept = issueValid && !stall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            // Increment cannot overflow: a full destination stalls the issue.
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= w_eff[r]
                          + {{(CNTW-1){1'b0}}, (w_accept && issueWr && (issueDst == C_SELW'(r)))};
            end
            r_err <= r_err || (|w_under);
        end
    end

    generate
        for (genvar g = 0; g < NREG; g++) begin : g_busy
            assign busyVec[g] = (r_cnt[g] != '0);
        end
    endgenerate

    assign err = r_err;

endmodule
`default_nettype wire
